vex_reader: RTL and testbench
=============================

VEX_READER -- requirements
Module: vex_reader

Interface
REQ-001 Parameter ADDR_W, default 13, width of the node-value RAM address.
REQ-002 Parameter DATA_W, default 64, width of one stored IEEE-754 double v_ex word.
REQ-003 Parameter RD_LAT, default 2, fixed RAM read latency: rddata is valid RD_LAT cycles after the rden cycle.
REQ-004 Parameter FIFO_DEPTH, default 4, output buffer entries; SHALL be at least RD_LAT+2.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse that begins a read pass.
REQ-008 num_nodes  input  ADDR_W+1  number of words to read; sampled on start.
REQ-009 rdaddr  output  ADDR_W  RAM read address.
REQ-010 rden  output  1  RAM read enable, one word per asserted cycle.
REQ-011 rddata  input  DATA_W  RAM read data.
REQ-012 out_data  output  DATA_W  streamed v_ex word.
REQ-013 out_valid  output  1  out_data holds a word.
REQ-014 out_ready  input  1  downstream accepts the word when out_valid and out_ready are both high.
REQ-015 busy  output  1  a pass is in progress.
REQ-016 done  output  1  one-cycle pulse when a pass completes.

Function
REQ-017 States SHALL be IDLE, READ, DRAIN and FINISH.
- IDLE -> READ on start with num_nodes>0.
- IDLE -> FINISH on start with num_nodes=0.
- READ -> DRAIN after the read of address num_nodes-1 is issued.
- DRAIN -> FINISH when no read is in flight, the FIFO is empty and the last word has been accepted.
- FINISH -> IDLE after one cycle.
REQ-018 start SHALL be ignored in any state other than IDLE.
REQ-019 Reads SHALL be issued to addresses 0,1,...,num_nodes-1 in ascending order, one per rden cycle.
REQ-020 The first rden SHALL occur in the cycle after the start cycle, with rdaddr=0.
REQ-021 In READ, rden SHALL be asserted only when (reads in flight + FIFO occupancy) < FIFO_DEPTH, so the FIFO never overflows.
REQ-022 rdaddr SHALL hold its last value while rden is low.
REQ-023 rddata SHALL be written into the FIFO exactly RD_LAT cycles after each rden cycle.
REQ-024 out_valid SHALL be registered and rise the cycle after a word enters an empty FIFO.
- With out_ready held high, the first out_valid SHALL appear RD_LAT+2 cycles after the start cycle.
REQ-025 With out_ready held high, throughput SHALL be one word per cycle with no bubbles.
REQ-026 out_data/out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-027 Words SHALL leave the FIFO in address order; none SHALL be lost or duplicated.
REQ-028 A FIFO push and pop in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-029 busy SHALL be high from the cycle after start through the FINISH cycle.
REQ-030 done SHALL be high only in the FINISH cycle.
REQ-031 num_nodes greater than 2^ADDR_W SHALL be clamped to 2^ADDR_W, so the address never wraps.
REQ-032 The word count SHALL use ADDR_W+1 bits so that 2^ADDR_W words are readable.

Reset
REQ-033 While rst is high:
- state SHALL be IDLE;
- rden, out_valid, busy and done SHALL be 0;
- rdaddr and out_data SHALL be 0;
- FIFO occupancy and the in-flight count SHALL be 0.
REQ-034 Reset asserted mid-pass SHALL abort the pass, discard in-flight read returns, and emit no done pulse.
REQ-035 After rst deasserts, the block SHALL accept start on the first clock edge.

Verification
REQ-036 The bench SHALL cover these scenarios:
- num_nodes=8, RAM[i]=i, out_ready=1 -> rden high 8 consecutive cycles; out_data 0..7 on consecutive cycles starting 4 cycles after start; done exactly one cycle after the last accept.
- num_nodes=8192, out_ready=1 -> addresses 0..8191 with no wrap; 8192 words accepted; done once.
- num_nodes=20, out_ready random 50% -> outputs in order 0..19 with stable data during stalls; rden never issued with 4 entries committed.
- num_nodes=0 -> no rden; done one cycle after start; busy high for one cycle.
- start pulsed again while busy -> no effect on the pass; exactly num_nodes outputs.
- rst asserted after 5 outputs of a 20-word pass -> all outputs zero immediately; a fresh pass of 3 words returns RAM[0..2] correctly with no stale data.

Source files
------------

// File: rtl/vex_reader_if.sv
// vex_reader_if: handshake/bus bundle for vex_reader.
//   start/num_nodes : pass request (num_nodes sampled with start)
//   rdaddr/rden/rddata : node-value RAM read port (fixed-latency return)
//   out_data/out_valid/out_ready : streamed v_ex words, valid/ready handshake
//   busy/done : pass status
// slave modport is the reader itself; master is the surrounding logic.
interface vex_reader_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 64
);
  logic              start;
  logic [ADDR_W:0]   num_nodes;
  logic [ADDR_W-1:0] rdaddr;
  logic              rden;
  logic [DATA_W-1:0] rddata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport slave (
    input  start, num_nodes, rddata, out_ready,
    output rdaddr, rden, out_data, out_valid, busy, done
  );

  modport master (
    output start, num_nodes, rddata, out_ready,
    input  rdaddr, rden, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/vex_reader.sv
// vex_reader: streams num_nodes v_ex words out of a fixed-latency RAM
// (addresses 0..num_nodes-1) through a small FIFO with valid/ready output.
//   clk : clock, all state on rising edge
//   rst : asynchronous active-high reset (aborts any pass, no done)
//   bus : vex_reader_if.slave (start/num_nodes, RAM read port,
//         output stream, busy/done)
// Reads are credit-limited so that words in flight plus words buffered
// never exceed FIFO_DEPTH; with FIFO_DEPTH >= RD_LAT+2 and out_ready high
// this sustains one word per cycle.
module vex_reader #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 64,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  vex_reader_if.slave  bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
  localparam logic [ADDR_W:0] MAX_N = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

  state_t            state;
  logic [ADDR_W:0]   total, issued;
  logic [ADDR_W-1:0] rdaddr_q;
  // vld_pipe[0] is rden itself; vld_pipe[k] = rden k cycles ago.
  logic [RD_LAT:0]   vld_pipe;
  logic              busy_q, done_q;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_nxt;
  logic              out_valid_q;

  logic              push, pop, credit_ok;
  logic [SW-1:0]     inflight;
  logic [ADDR_W:0]   n_clamp;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push      = vld_pipe[RD_LAT];
  assign pop       = out_valid_q & bus.out_ready;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign n_clamp   = (bus.num_nodes > MAX_N) ? MAX_N : bus.num_nodes;

  // Reads still outstanding after this edge (the one returning now is
  // already counted in count_nxt).
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + SW'(vld_pipe[i]);
  end

  assign credit_ok = (SW'(count_nxt) + inflight) < SW'(FIFO_DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      total    <= '0;
      issued   <= '0;
      rdaddr_q <= '0;
      vld_pipe <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[RD_LAT-1:0], 1'b0};
      done_q   <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          busy_q <= 1'b1;
          if (n_clamp == '0) begin
            state  <= FINISH;
            done_q <= 1'b1;
          end else begin
            // FIFO is empty in IDLE, so the first read needs no credit check.
            state       <= READ;
            total       <= n_clamp;
            issued      <= {{ADDR_W{1'b0}}, 1'b1};
            rdaddr_q    <= '0;
            vld_pipe[0] <= 1'b1;
          end
        end
        READ: begin
          if (issued == total) begin
            state <= DRAIN;
          end else if (credit_ok) begin
            vld_pipe[0] <= 1'b1;
            rdaddr_q    <= issued[ADDR_W-1:0];
            issued      <= issued + 1'b1;
          end
        end
        DRAIN: if (vld_pipe[RD_LAT-1:0] == '0 && count_nxt == '0) begin
          state  <= FINISH;
          done_q <= 1'b1;
        end
        FINISH: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.rddata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count       <= count_nxt;
      out_valid_q <= (count_nxt != '0);
    end
  end

  // Head entry is never overwritten while occupied, so out_data is stable
  // across stalls.
  assign bus.out_data  = mem[rd_ptr];
  assign bus.out_valid = out_valid_q;
  assign bus.rden      = vld_pipe[0];
  assign bus.rdaddr    = rdaddr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_vex_reader.sv
// tb_vex_reader: directed bench for vex_reader with a 2-cycle RAM model
// (RAM[i] = i) and a negedge monitor that tracks ordering, stalls and credit.
module tb_vex_reader;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vex_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vex_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // RAM model: data valid two cycles after the rden cycle.
  logic [DATA_W-1:0] ram_p1;
  always @(posedge clk) begin
    ram_p1     <= bus.rden ? DATA_W'(bus.rdaddr) : 64'hDEAD_BEEF_DEAD_BEEF;
    bus.rddata <= ram_p1;
  end

  bit rdy_mode = 1'b0;
  always @(posedge clk) begin
    #1 bus.out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor
  bit mon_clr = 1'b1;
  int cyc = 0, start_cyc, first_rden, last_rden, first_valid, last_acc, done_cyc;
  int rden_cnt, acc_cnt, done_cnt, busy_cnt, committed, exp_addr, exp_out;
  int addr_err, ord_err, stall_err, credit_err;
  logic pv, pr;
  logic [DATA_W-1:0] pd;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mon_clr) begin
      start_cyc <= -1; first_rden <= -1; last_rden <= -1; first_valid <= -1;
      last_acc <= -1; done_cyc <= -1; rden_cnt <= 0; acc_cnt <= 0; done_cnt <= 0;
      busy_cnt <= 0; committed <= 0; exp_addr <= 0; exp_out <= 0; addr_err <= 0;
      ord_err <= 0; stall_err <= 0; credit_err <= 0; pv <= 1'b0; pr <= 1'b1; pd <= '0;
    end else begin
      if (bus.start && !bus.busy) start_cyc <= cyc;
      if (bus.rden) begin
        if (int'(bus.rdaddr) != exp_addr) addr_err <= addr_err + 1;
        if (committed >= 4) credit_err <= credit_err + 1;
        exp_addr <= exp_addr + 1;
        rden_cnt <= rden_cnt + 1;
        if (first_rden < 0) first_rden <= cyc;
        last_rden <= cyc;
      end
      committed <= committed + int'(bus.rden) - int'(bus.out_valid && bus.out_ready);
      if (bus.out_valid && bus.out_ready) begin
        if (bus.out_data != DATA_W'(exp_out)) ord_err <= ord_err + 1;
        exp_out  <= exp_out + 1;
        acc_cnt  <= acc_cnt + 1;
        last_acc <= cyc;
      end
      if (bus.out_valid && first_valid < 0) first_valid <= cyc;
      if (pv && !pr && (!bus.out_valid || bus.out_data != pd)) stall_err <= stall_err + 1;
      pv <= bus.out_valid; pr <= bus.out_ready; pd <= bus.out_data;
      if (bus.busy) busy_cnt <= busy_cnt + 1;
      if (bus.done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
  end

  task automatic clear_mon();
    @(posedge clk); #1 mon_clr = 1'b1;
    @(negedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic pulse_start(input int n);
    @(posedge clk); #1 bus.start = 1'b1; bus.num_nodes = (ADDR_W+1)'(n);
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk({tag, "_no_timeout"}, 64'(done_cnt > 0), 64'd1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.num_nodes = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rden", 64'(bus.rden), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_rdaddr", 64'(bus.rdaddr), 64'd0);
    chk("rst_data", bus.out_data, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 8 words, ready held high
    rdy_mode = 1'b0;
    clear_mon(); pulse_start(8); wait_done("t8", 200);
    chk("t8_first_rden", 64'(first_rden - start_cyc), 64'd1);
    chk("t8_rden_cnt", 64'(rden_cnt), 64'd8);
    chk("t8_rden_span", 64'(last_rden - first_rden), 64'd7);
    chk("t8_first_valid", 64'(first_valid - start_cyc), 64'd4);
    chk("t8_acc_cnt", 64'(acc_cnt), 64'd8);
    chk("t8_no_bubble", 64'(last_acc - first_valid), 64'd7);
    chk("t8_order", 64'(ord_err), 64'd0);
    chk("t8_addr", 64'(addr_err), 64'd0);
    chk("t8_done_lat", 64'(done_cyc - last_acc), 64'd1);
    chk("t8_done_cnt", 64'(done_cnt), 64'd1);
    chk("t8_busy_cyc", 64'(busy_cnt), 64'(done_cyc - start_cyc));

    // full address space
    clear_mon(); pulse_start(8192); wait_done("t8192", 9000);
    chk("t8192_rden_cnt", 64'(rden_cnt), 64'd8192);
    chk("t8192_addr", 64'(addr_err), 64'd0);
    chk("t8192_acc_cnt", 64'(acc_cnt), 64'd8192);
    chk("t8192_order", 64'(ord_err), 64'd0);
    chk("t8192_done_cnt", 64'(done_cnt), 64'd1);

    // oversize count clamps to 8192
    clear_mon(); pulse_start(16383); wait_done("tclamp", 9000);
    chk("tclamp_rden_cnt", 64'(rden_cnt), 64'd8192);
    chk("tclamp_addr", 64'(addr_err), 64'd0);
    chk("tclamp_acc_cnt", 64'(acc_cnt), 64'd8192);

    // 20 words, random backpressure
    rdy_mode = 1'b1;
    clear_mon(); pulse_start(20); wait_done("trnd", 400);
    chk("trnd_acc_cnt", 64'(acc_cnt), 64'd20);
    chk("trnd_order", 64'(ord_err), 64'd0);
    chk("trnd_stall", 64'(stall_err), 64'd0);
    chk("trnd_credit", 64'(credit_err), 64'd0);
    chk("trnd_done_cnt", 64'(done_cnt), 64'd1);
    rdy_mode = 1'b0;

    // zero-length pass
    clear_mon(); pulse_start(0); wait_done("t0", 20);
    chk("t0_rden_cnt", 64'(rden_cnt), 64'd0);
    chk("t0_done_lat", 64'(done_cyc - start_cyc), 64'd1);
    chk("t0_busy_cnt", 64'(busy_cnt), 64'd1);
    chk("t0_valid", 64'(first_valid), 64'hFFFF_FFFF_FFFF_FFFF);

    // start re-pulsed while busy is ignored
    clear_mon(); pulse_start(8);
    repeat (2) @(posedge clk);
    #1 bus.start = 1'b1; bus.num_nodes = 14'd3;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done("tre", 200);
    chk("tre_acc_cnt", 64'(acc_cnt), 64'd8);
    chk("tre_rden_cnt", 64'(rden_cnt), 64'd8);
    chk("tre_order", 64'(ord_err), 64'd0);
    chk("tre_done_cnt", 64'(done_cnt), 64'd1);

    // reset mid-pass, then a fresh 3-word pass
    clear_mon(); pulse_start(20);
    begin
      int k = 0;
      while (acc_cnt < 5 && k < 200) begin
        @(negedge clk); #1;
        k++;
      end
    end
    chk("trst_reach5", 64'(acc_cnt >= 5), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("trst_valid", 64'(bus.out_valid), 64'd0);
    chk("trst_data", bus.out_data, 64'd0);
    chk("trst_rden", 64'(bus.rden), 64'd0);
    chk("trst_rdaddr", 64'(bus.rdaddr), 64'd0);
    chk("trst_busy", 64'(bus.busy), 64'd0);
    #1 chk("trst_no_done", 64'(done_cnt), 64'd0);
    mon_clr = 1'b1;
    @(negedge clk); #1 mon_clr = 1'b0;
    @(posedge clk); #1 rst = 1'b0; bus.start = 1'b1; bus.num_nodes = 14'd3;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done("tfresh", 100);
    chk("tfresh_first_rden", 64'(first_rden - start_cyc), 64'd1);
    chk("tfresh_acc_cnt", 64'(acc_cnt), 64'd3);
    chk("tfresh_order", 64'(ord_err), 64'd0);
    chk("tfresh_done_cnt", 64'(done_cnt), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
